seq_alu: RTL
============

Name: seq_alu

Overview:
Parametrised, registered ALU for the datapath. It generalises the 16-bit, 4-op combinational ALU to WIDTH bits and 8 ops, including a multi-cycle unsigned shift-add multiply. Operands are captured on a start/done handshake. Result and Z/N/V status are held in registers until the next completed op, so the controller FSM sequences against done instead of relying on fixed combinational timing.

Parameters:
WIDTH, 16, datapath width of ain, bin and result; must be >= 4 and a power of two.
SHW, $clog2(WIDTH), shift-amount width (derived; not to be overridden).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  op request; sampled only when busy=0
op  input  3  operation code, sampled with start
ain  input  WIDTH  operand A, sampled with start
bin  input  WIDTH  operand B, sampled with start
result  output  WIDTH  registered result of the last completed op
status  output  3  registered flags: [0]=Z, [1]=N, [2]=V
busy  output  1  high while a multiply is iterating
done  output  1  one-cycle pulse when result and status update

Behaviour:
- Reset, synchronous and active-high: the next edge forces state IDLE and result=0, status=0, busy=0, done=0. Reset wins over start. Reset during MUL aborts it, and no done is produced.
- Op encodings:
  - 000 ADD: A+B
  - 001 SUB: A-B
  - 010 AND: A&B
  - 011 NOTB: ~B
  - 100 OR: A|B
  - 101 XOR: A^B
  - 110 SHL: A << B[SHW-1:0], zero fill
  - 111 MUL: unsigned A*B, low WIDTH bits kept
- State machine, IDLE -> MUL -> IDLE:
  - IDLE + start + op!=111: on that edge, register result and status, assert done for the next cycle, stay in IDLE. Latency is 1 cycle.
  - IDLE + start + op==111: on that edge, latch operands, clear the 2*WIDTH-bit accumulator and iteration counter, go to MUL. busy=1 from the next cycle.
  - MUL: one shift-add iteration per cycle, exactly WIDTH cycles. On the final iteration edge: register result and status, go to IDLE, busy=0, done=1. done therefore arrives WIDTH+1 cycles after the start cycle.
  - start while busy=1 is ignored and has no effect on operands.
  - start is accepted in the cycle done is high, so back-to-back issue is allowed.
- Flags, computed from the WIDTH-bit result written:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - V for ADD/SUB = signed two's-complement overflow (carry into MSB xor carry out of MSB).
  - V for MUL = 1 if any of product bits [2*WIDTH-1:WIDTH] is nonzero.
  - V = 0 for all other ops.
- SUB is implemented as A + ~B + 1. ADD/SUB wrap modulo 2^WIDTH.
- result and status hold their value between done pulses. Nothing updates except on done.

Decomposition:
- Package alu_pkg:
  - op code constants (OP_ADD .. OP_MUL)
  - status bit index constants (ST_Z=0, ST_N=1, ST_V=2)
  - FSM state encodings (S_IDLE, S_MUL)
- Sub-module addsub_ovf #(WIDTH): combinational add/sub with a signed-overflow output, reused for ADD/SUB.
- The multiply iterator stays inline in seq_alu; it is too small to split out.

Test Plan (WIDTH=16):
- ADD 0x7FFF + 0x0001 -> one cycle later: done=1, result=0x8000, status=3'b110; busy never high.
- SUB 0x0005 - 0x0005 -> result=0x0000, status=3'b001. Then SHL ain=0x0001, bin=0x0013 issued the next cycle -> result=0x0008, status=3'b000.
- MUL 300 * 200 -> busy=1 for 16 cycles, done 17 cycles after start, result=0xEA60, status=3'b010. A start(ADD 1+1) pulsed mid-iteration is ignored, and the result stays 0xEA60.
- MUL 0x0100 * 0x0100 -> result=0x0000, status=3'b101 (Z=1, V=1).
- NOTB bin=0x00FF, then OR 0xF000 | 0x000F, then XOR 0xFFFF ^ 0xFFFF, each on back-to-back starts -> results 0xFF00/0x010, 0xF00F/0x010, 0x0000/0x001, with one done per op.
- Reset asserted in the 5th cycle of a MUL -> next cycle: busy=0, result=0, status=0. No done appears afterward, and a new ADD 2+3 then returns 0x0005 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, status bit positions and FSM states for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOTB = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam int unsigned ST_Z = 0;
  localparam int unsigned ST_N = 1;
  localparam int unsigned ST_V = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  // Assemble the 3-bit status word from individual flags.
  function automatic logic [2:0] pack_status(input logic z, input logic n, input logic v);
    logic [2:0] s;
    s       = 3'b000;
    s[ST_Z] = z;
    s[ST_N] = n;
    s[ST_V] = v;
    return s;
  endfunction

endpackage

// File: rtl/addsub_ovf.sv
// Combinational adder/subtractor (A + B or A + ~B + 1) with signed-overflow flag.
module addsub_ovf #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum_c,
  output logic             ovf_c
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] low;
  logic [1:0]       top;
  logic             c_msb_in;

  // Split the add at the MSB so carry-in and carry-out of the MSB are both visible.
  always_comb begin
    b_eff    = sub ? ~b : b;
    low      = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + WIDTH'(sub);
    c_msb_in = low[WIDTH-1];
    top      = 2'(a[WIDTH-1]) + 2'(b_eff[WIDTH-1]) + 2'(c_msb_in);
    sum_c    = {top[0], low[WIDTH-2:0]};
    ovf_c    = top[1] ^ c_msb_in;
  end

endmodule

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with start/done handshake and an iterative shift-add multiply.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PW = 2 * WIDTH;

  state_t           state;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [PW-1:0]    acc_q;
  logic [SHW-1:0]   cnt_q;

  logic [WIDTH-1:0] as_sum_c;
  logic             as_ovf_c;
  logic [WIDTH-1:0] alu_res_c;
  logic             alu_v_c;
  logic [PW-1:0]    acc_next_c;
  logic [WIDTH-1:0] prod_lo_c;
  logic             prod_v_c;

  addsub_ovf #(.WIDTH(WIDTH)) u_addsub (
    .a     (ain),
    .b     (bin),
    .sub   (op == OP_SUB),
    .sum_c (as_sum_c),
    .ovf_c (as_ovf_c)
  );

  // Single-cycle op result and overflow flag.
  always_comb begin
    alu_res_c = '0;
    alu_v_c   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res_c = as_sum_c;
        alu_v_c   = as_ovf_c;
      end
      OP_AND:  alu_res_c = ain & bin;
      OP_NOTB: alu_res_c = ~bin;
      OP_OR:   alu_res_c = ain | bin;
      OP_XOR:  alu_res_c = ain ^ bin;
      OP_SHL:  alu_res_c = ain << bin[SHW-1:0];
      default: alu_res_c = '0;
    endcase
  end

  // One shift-add step; the final step's value is the full product.
  always_comb begin
    acc_next_c = acc_q + (mplier_q[0] ? mcand_q : PW'(0));
    prod_lo_c  = acc_next_c[WIDTH-1:0];
    prod_v_c   = |acc_next_c[PW-1:WIDTH];
  end

  // Control FSM, multiply iterator and registered result/status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result   <= '0;
      status   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand_q  <= PW'(ain);
              mplier_q <= bin;
              acc_q    <= '0;
              cnt_q    <= '0;
              busy     <= 1'b1;
              state    <= S_MUL;
            end else begin
              result <= alu_res_c;
              status <= pack_status(alu_res_c == '0, alu_res_c[WIDTH-1], alu_v_c);
              done   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q    <= acc_next_c;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SHW'(1);
          if (cnt_q == SHW'(WIDTH - 1)) begin
            result <= prod_lo_c;
            status <= pack_status(prod_lo_c == '0, prod_lo_c[WIDTH-1], prod_v_c);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
